demux_sched: RTL and testbench

- Sequencing controller for the 1-to-4 demultiplexer datapath.
- Accepts a single input word stream with a valid/ready handshake and delivers each word to exactly one of 4 output channels.
- Destination comes from the input select (direct mode) or from an internal round-robin pointer (RR mode).
- Registers the word and drives a one-hot channel valid, so outputs are never X or undefined, unlike a bare combinational demux.

---
 rtl/demux_pkg.sv | 22 ++
 rtl/rr_ptr_ctr.sv | 29 ++
 rtl/demux_sched.sv | 103 ++++++++++
 tb/tb_demux_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_sched shared definitions.
// Channel count, select width, FSM states, one-hot helper.
package demux_pkg;

  localparam int N  = 4;
  localparam int SW = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } st_e;

  function automatic logic [N-1:0] onehot(
    input logic [SW-1:0] sel
  );
    logic [N-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_ptr_ctr.sv
// Round-robin destination pointer.
// Modulo-4 counter, advances on inc_i.
module rr_ptr_ctr
  import demux_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  output logic [SW-1:0] ptr_o
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  // Next pointer: natural 2-bit wrap gives 3 -> 0.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/demux_sched.sv
// 1-to-4 demux sequencer: registered word, one-hot valid.
// Direct or round-robin destination, AXI-like output hold.
module demux_sched
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          En,
  input  logic          mode,
  input  logic [W-1:0]  d,
  input  logic [SW-1:0] s,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  o,
  output logic [N-1:0]  o_valid,
  input  logic [N-1:0]  o_ready,
  output logic [SW-1:0] rr_ptr,
  output logic [7:0]    cnt
);

  st_e           st_q, st_d;
  logic [W-1:0]  o_q, o_d;
  logic [N-1:0]  ov_q, ov_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rdy;
  logic          acc;
  logic          dlv;
  logic [SW-1:0] dst;
  logic [SW-1:0] ptr;

  // Only the destination's ready bit matters; others are masked off.
  assign dlv = (st_q == FULL) & (|(ov_q & o_ready));
  assign acc = in_valid & rdy;
  assign dst = mode ? ptr : s;

  rr_ptr_ctr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (acc & mode),
    .ptr_o (ptr)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= EMPTY;
    else        st_q <= st_d;
  end

  // FSM next state: a delivery with a refill stays FULL.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      EMPTY: if (acc) st_d = FULL;
      FULL:  if (dlv && !acc) st_d = EMPTY;
    endcase
  end

  // FSM output: accept when empty or when the held word leaves now.
  always_comb begin
    rdy = 1'b0;
    unique case (st_q)
      EMPTY: rdy = En;
      FULL:  rdy = En & dlv;
    endcase
    rdy = rdy & rst_n;
  end

  // Datapath next values: load on accept, drop valid on drain.
  always_comb begin
    o_d   = o_q;
    ov_d  = ov_q;
    cnt_d = cnt_q;
    if (acc) begin
      o_d  = d;
      ov_d = onehot(dst);
    end else if (dlv) begin
      ov_d = '0;
    end
    if (dlv) cnt_d = cnt_q + 8'd1;
  end

  // Datapath registers; reset drops any held word uncounted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q   <= '0;
      ov_q  <= '0;
      cnt_q <= '0;
    end else begin
      o_q   <= o_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready = rdy;
  assign o        = o_q;
  assign o_valid  = ov_q;
  assign rr_ptr   = ptr;
  assign cnt      = cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
// demux_sched bench: directed words, scoreboard of
// expected (word, channel) popped on each delivery.
module tb_demux_sched;

  logic       clk;
  logic       rst_n;
  logic       En;
  logic       mode;
  logic [7:0] d;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] o;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic [1:0] rr_ptr;
  logic [7:0] cnt;

  typedef struct {
    logic [7:0] w;
    logic [3:0] oh;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = 8'd0;

  demux_sched #(.W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .En       (En),
    .mode     (mode),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o        (o),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .rr_ptr   (rr_ptr),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h need %0h", nm, act, exp);
    end
  endtask

  task automatic send(
    input  logic [7:0] dd,
    input  logic [1:0] ss,
    input  logic [3:0] oh,
    output int         waits
  );
    waits = 0;
    d = dd;
    s = ss;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waits < 64) begin
      @(posedge clk);
      #2;
      waits++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout d=%h: got in_ready=0 need 1", dd);
    end else begin
      q.push_back('{dd, oh});
      exp_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a delivery happens at the next edge when valid meets ready.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!$onehot0(o_valid) || $isunknown(o_valid)) begin
      errors++;
      $display("FAIL onehot: got o_valid=%b need <=1 bit", o_valid);
    end
    if (rst_n && ((o_valid & o_ready) != 4'b0)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dlv: got o=%h v=%b need none", o, o_valid);
      end else begin
        e = q.pop_front();
        if (o !== e.w || o_valid !== e.oh) begin
          errors++;
          $display("FAIL dlv: got o=%h v=%b need o=%h v=%b",
                   o, o_valid, e.w, e.oh);
        end
      end
    end
  end

  logic [7:0] dv[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [1:0] sv[4] = '{2'd3, 2'd0, 2'd2, 2'd1};
  logic [3:0] ov[4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};

  initial begin
    int w;
    rst_n = 1'b0;
    En = 1'b1;
    mode = 1'b0;
    d = 8'h00;
    s = 2'd0;
    in_valid = 1'b0;
    o_ready = 4'b0000;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_o", o, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_rr", rr_ptr, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;

    // reset while holding a word for channel 2
    send(8'hA5, 2'd2, 4'b0100, w);
    tick();
    chk("hold_v", o_valid, 4'b0100);
    chk("hold_o", o, 8'hA5);
    rst_n = 1'b0;
    tick();
    q.delete();
    exp_cnt = 8'd0;
    rst_n = 1'b1;
    chk("mid_rst_v", o_valid, 0);
    chk("mid_rst_o", o, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_rr", rr_ptr, 0);
    o_ready = 4'b1111;
    repeat (3) tick();
    chk("mid_rst_nodlv", cnt, 0);

    // direct mode, back to back
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(dv[i], sv[i], ov[i], w);
      chk("direct_ready", w, 0);
    end
    tick();
    chk("direct_cnt", cnt, 4);
    chk("direct_rr", rr_ptr, 0);

    // round-robin, wraps past channel 3; s is ignored
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), 2'(3 - (i % 4)), 4'(1 << (i % 4)), w);
    end
    tick();
    chk("rr_ptr_end", rr_ptr, 2);
    chk("rr_cnt", cnt, 10);
    send(8'h07, 2'd0, 4'b0100, w);
    send(8'h08, 2'd0, 4'b1000, w);
    send(8'h09, 2'd0, 4'b0001, w);
    tick();
    chk("rr_ptr_1", rr_ptr, 1);

    // backpressure on channel 1 for 3 cycles
    o_ready = 4'b1101;
    send(8'hB1, 2'd0, 4'b0010, w);
    in_valid = 1'b1;
    d = 8'hB2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_o", o, 8'hB1);
      chk("bp_v", o_valid, 4'b0010);
      chk("bp_ready", in_ready, 0);
      tick();
    end
    o_ready = 4'b1111;
    send(8'hB2, 2'd0, 4'b0100, w);
    chk("bp_4th", w, 0);
    tick();
    chk("bp_cnt", cnt, 15);
    chk("bp_rr", rr_ptr, 3);

    // enable low drains held word, blocks new one
    mode = 1'b0;
    o_ready = 4'b0000;
    send(8'hC0, 2'd0, 4'b0001, w);
    En = 1'b0;
    in_valid = 1'b1;
    d = 8'hC1;
    s = 2'd1;
    o_ready = 4'b1111;
    #1;
    chk("en_ready", in_ready, 0);
    tick();
    chk("en_v", o_valid, 0);
    chk("en_cnt", cnt, 16);
    chk("en_rr", rr_ptr, 3);
    #1;
    chk("en_ready2", in_ready, 0);
    in_valid = 1'b0;
    En = 1'b1;

    // 256 deliveries wrap cnt
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 2'(i % 4), 4'(1 << (i % 4)), w);
    end
    tick();
    chk("wrap_cnt", cnt, 0);
    chk("wrap_model", cnt, int'(exp_cnt));

    // mode switch while FULL keeps channel 0
    mode = 1'b1;
    o_ready = 4'b0000;
    send(8'hD5, 2'd3, 4'b0001, w);
    mode = 1'b0;
    s = 2'd3;
    repeat (2) tick();
    chk("sw_v", o_valid, 4'b0001);
    chk("sw_rr", rr_ptr, 1);
    o_ready = 4'b1111;
    repeat (2) tick();
    chk("sw_cnt", cnt, 1);
    chk("sw_v0", o_valid, 0);

    chk("q_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
